// File: rtl/port_serializer.sv
// -----------------------------------------------------------------------------
// port_serializer
//   Output-side parallel-to-serial stage for one router output port. Pops
//   payload words over a valid/ready handshake and shifts them out LSB-first
//   on the dout / valido_n / frameo_n serial triple. frameo_n is held low
//   for the whole packet except during its final bit. After the final bit,
//   GAP_CYCLES idle cycles are forced before the next packet can start.
//
// Parameters
//   DATA_W      payload word width (>= 2)
//   GAP_CYCLES  idle cycles forced after each packet's final bit (>= 1)
//
// Ports
//   clock       rising-edge clock
//   reset_n     asynchronous active-low reset
//   byte_data   payload word, bit 0 sent first
//   byte_last   word is the final word of its packet (valid with byte_valid)
//   byte_valid  upstream word present
//   byte_ready  word accepted this cycle (transfer = valid & ready)
//   dout        serial data bit
//   valido_n    active-low: dout carries a payload bit
//   frameo_n    active-low packet frame
//   busy        state != IDLE
//   pkt_done    one-cycle pulse during the final bit of each packet
// -----------------------------------------------------------------------------
module port_serializer #(
  parameter int DATA_W     = 8,
  parameter int GAP_CYCLES = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] byte_data,
  input  logic              byte_last,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              dout,
  output logic              valido_n,
  output logic              frameo_n,
  output logic              busy,
  output logic              pkt_done
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_STALL = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  state_t             state_q,  state_d;
  logic [DATA_W-1:0]  shreg_q,  shreg_d;
  logic [CNT_W-1:0]   bitcnt_q, bitcnt_d;
  logic               last_q,   last_d;
  logic [GAP_W-1:0]   gapcnt_q, gapcnt_d;

  logic word_end;   // final bit of the current word is on the wire
  logic pkt_end;    // final bit of the packet is on the wire
  logic xfer;

  assign word_end = (state_q == ST_SHIFT) && (bitcnt_q == LAST_BIT);
  assign pkt_end  = word_end && last_q;

  // The only input-dependent output is byte_ready; it is also gated by
  // reset_n so nothing is accepted while reset is held.
  assign byte_ready = reset_n &&
                      ((state_q == ST_IDLE) || (state_q == ST_STALL) ||
                       (word_end && !last_q));
  assign xfer = byte_valid && byte_ready;

  // The shift register moves right each bit, so bit bitcnt of the loaded
  // word always sits at shreg_q[0].
  assign dout     = (state_q == ST_SHIFT) && shreg_q[0];
  assign valido_n = (state_q != ST_SHIFT);
  assign frameo_n = !(((state_q == ST_SHIFT) && !pkt_end) ||
                      (state_q == ST_STALL));
  assign busy     = (state_q != ST_IDLE);
  assign pkt_done = pkt_end;

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    last_d   = last_q;
    gapcnt_d = gapcnt_q;
    unique case (state_q)
      ST_IDLE, ST_STALL: begin
        if (xfer) begin
          state_d  = ST_SHIFT;
          shreg_d  = byte_data;
          last_d   = byte_last;
          bitcnt_d = '0;
        end
      end
      ST_SHIFT: begin
        if (word_end) begin
          if (last_q) begin
            state_d  = ST_GAP;
            gapcnt_d = GAP_INIT;
          end else if (xfer) begin
            // next word follows with no bubble
            shreg_d  = byte_data;
            last_d   = byte_last;
            bitcnt_d = '0;
          end else begin
            state_d = ST_STALL;
          end
        end else begin
          shreg_d  = shreg_q >> 1;
          bitcnt_d = bitcnt_q + CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (gapcnt_q == '0) state_d = ST_IDLE;
        else                gapcnt_d = gapcnt_q - GAP_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      last_q   <= 1'b0;
      gapcnt_q <= '0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      last_q   <= last_d;
      gapcnt_q <= gapcnt_d;
    end
  end

endmodule

// File: tb/tb_port_serializer.sv
// -----------------------------------------------------------------------------
// tb_port_serializer
//   Directed bench for port_serializer (DATA_W=8, GAP_CYCLES=3). Inputs are
//   driven 1 time unit after the rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_port_serializer;

  localparam int DW  = 8;
  localparam int GAP = 3;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic [DW-1:0] byte_data = '0;
  logic          byte_last = 1'b0;
  logic          byte_valid = 1'b0;
  logic          byte_ready, dout, valido_n, frameo_n, busy, pkt_done;

  int n_vec = 0;
  int n_err = 0;

  port_serializer #(.DATA_W(DW), .GAP_CYCLES(GAP)) u_dut (
    .clock(clock), .reset_n(reset_n),
    .byte_data(byte_data), .byte_last(byte_last), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .dout(dout), .valido_n(valido_n),
    .frameo_n(frameo_n), .busy(busy), .pkt_done(pkt_done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Enters with bit 0 of `data` on the wire; checks all DW bit cycles.
  // The next word (nv/nd/nl) is presented during the final bit.
  task automatic shift_word(input string tag, input logic [DW-1:0] data,
                            input logic last, input logic nv,
                            input logic [DW-1:0] nd, input logic nl);
    for (int i = 0; i < DW; i++) begin
      chk({tag, "_dout"},   dout,       data[i]);
      chk({tag, "_vld"},    valido_n,   1'b0);
      chk({tag, "_frame"},  frameo_n,   (i == DW-1) && last);
      chk({tag, "_done"},   pkt_done,   (i == DW-1) && last);
      chk({tag, "_ready"},  byte_ready, (i == DW-1) && !last);
      chk({tag, "_busy"},   busy,       1'b1);
      if (i == DW-1) begin
        byte_valid = nv;
        byte_data  = nd;
        byte_last  = nl;
      end
      step();
    end
  endtask

  task automatic gap_check(input string tag);
    for (int i = 0; i < GAP; i++) begin
      chk({tag, "_gframe"}, frameo_n,   1'b1);
      chk({tag, "_gvld"},   valido_n,   1'b1);
      chk({tag, "_gdout"},  dout,       1'b0);
      chk({tag, "_gready"}, byte_ready, 1'b0);
      chk({tag, "_gbusy"},  busy,       1'b1);
      step();
    end
    chk({tag, "_idle_busy"},  busy,       1'b0);
    chk({tag, "_idle_ready"}, byte_ready, 1'b1);
    chk({tag, "_idle_frame"}, frameo_n,   1'b1);
  endtask

  // random-section state
  int            len, vptr, wcnt, bcnt, cyc;
  logic [DW-1:0] words [16];
  logic [DW-1:0] rx;
  logic          in_pkt, done, xfer, final_bit;

  initial begin
    // ---- reset values ----
    repeat (2) @(posedge clock);
    #1;
    chk("rst_ready", byte_ready, 1'b0);
    chk("rst_frame", frameo_n,   1'b1);
    chk("rst_vld",   valido_n,   1'b1);
    chk("rst_dout",  dout,       1'b0);
    chk("rst_busy",  busy,       1'b0);
    chk("rst_done",  pkt_done,   1'b0);
    #2 reset_n = 1'b1;
    step();

    // ---- single 1-word packet 0xA5 ----
    chk("t1_ready", byte_ready, 1'b1);
    byte_valid = 1'b1; byte_data = 8'hA5; byte_last = 1'b1;
    step();
    byte_valid = 1'b0;
    shift_word("t1", 8'hA5, 1'b1, 1'b0, 8'h00, 1'b0);
    gap_check("t1");

    // ---- 3-word packet, valid held high ----
    byte_valid = 1'b1; byte_data = 8'h01; byte_last = 1'b0;
    step();
    shift_word("t2w1", 8'h01, 1'b0, 1'b1, 8'h80, 1'b0);
    shift_word("t2w2", 8'h80, 1'b0, 1'b1, 8'hFF, 1'b1);
    shift_word("t2w3", 8'hFF, 1'b1, 1'b0, 8'h00, 1'b0);
    gap_check("t2");

    // ---- underrun: 5 stall cycles between words ----
    byte_valid = 1'b1; byte_data = 8'h3C; byte_last = 1'b0;
    step();
    shift_word("t3w1", 8'h3C, 1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("t3_sframe", frameo_n,   1'b0);
      chk("t3_svld",   valido_n,   1'b1);
      chk("t3_sdout",  dout,       1'b0);
      chk("t3_sready", byte_ready, 1'b1);
      chk("t3_sbusy",  busy,       1'b1);
      if (i == 4) begin
        byte_valid = 1'b1; byte_data = 8'hC3; byte_last = 1'b1;
      end
      step();
    end
    byte_valid = 1'b0;
    shift_word("t3w2", 8'hC3, 1'b1, 1'b0, 8'h00, 1'b0);
    gap_check("t3");

    // ---- back-to-back packets, next packet valid throughout the gap ----
    byte_valid = 1'b1; byte_data = 8'h5A; byte_last = 1'b1;
    step();
    shift_word("t4p1", 8'h5A, 1'b1, 1'b1, 8'h96, 1'b1);
    gap_check("t4");   // GAP cycles plus the IDLE accept cycle = 4 idle cycles
    step();
    byte_valid = 1'b0;
    shift_word("t4p2", 8'h96, 1'b1, 1'b0, 8'h00, 1'b0);
    gap_check("t4b");

    // ---- reset at bit 3 of word 2 ----
    byte_valid = 1'b1; byte_data = 8'h11; byte_last = 1'b0;
    step();
    shift_word("t5w1", 8'h11, 1'b0, 1'b1, 8'h22, 1'b0);
    byte_valid = 1'b0;
    repeat (3) step();
    chk("t5_bit3", dout, 1'b0);          // 0x22 bit 3
    chk("t5_bit3_vld", valido_n, 1'b0);
    reset_n = 1'b0;
    #1;
    chk("t5_rframe", frameo_n,   1'b1);
    chk("t5_rvld",   valido_n,   1'b1);
    chk("t5_rbusy",  busy,       1'b0);
    chk("t5_rready", byte_ready, 1'b0);
    chk("t5_rdout",  dout,       1'b0);
    #2 reset_n = 1'b1;
    byte_valid = 1'b1; byte_data = 8'hE7; byte_last = 1'b1;
    step();
    byte_valid = 1'b0;
    shift_word("t5p", 8'hE7, 1'b1, 1'b0, 8'h00, 1'b0);
    gap_check("t5");

    // ---- random packets vs scoreboard ----
    for (int p = 0; p < 6; p++) begin
      len = $urandom_range(1, 16);
      for (int w = 0; w < 16; w++) words[w] = DW'($urandom_range(0, 255));
      vptr = 0; wcnt = 0; bcnt = 0; cyc = 0; in_pkt = 1'b0; done = 1'b0;
      rx = '0;
      byte_valid = ($urandom_range(0, 3) != 0);
      byte_data  = words[0];
      byte_last  = (len == 1);
      while (!done && cyc < 2000) begin
        xfer = byte_valid && byte_ready;
        step();
        cyc++;
        if (xfer) vptr++;
        if (valido_n == 1'b0) begin
          final_bit = (wcnt == len-1) && (bcnt == DW-1);
          chk("rnd_frame", frameo_n, final_bit);
          chk("rnd_done",  pkt_done, final_bit);
          rx[bcnt] = dout;
          bcnt++;
          in_pkt = !final_bit;
          if (bcnt == DW) begin
            chk("rnd_word", rx, words[wcnt]);
            wcnt++;
            bcnt = 0;
            if (wcnt == len) done = 1'b1;
          end
        end else begin
          chk("rnd_iframe", frameo_n, !in_pkt);
          chk("rnd_idout",  dout,     1'b0);
        end
        if (vptr < len) begin
          byte_valid = ($urandom_range(0, 3) != 0);
          byte_data  = words[vptr];
          byte_last  = (vptr == len-1);
        end else begin
          byte_valid = 1'b0;
        end
      end
      chk("rnd_complete", done, 1'b1);
      chk("rnd_popped", vptr, len);
      cyc = 0;
      while (busy && cyc < 20) begin
        step();
        cyc++;
      end
      chk("rnd_idle", busy, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
